// File: rtl/wb_commit_if.sv
// Memory-stage to writeback handshake and register-file write port bundle.
interface wb_commit_if;
  logic        inValid;
  logic        inReady;
  logic [4:0]  inDest;
  logic [1:0]  resultSel;
  logic [31:0] aluResult;
  logic [31:0] linkAddr;
  logic [1:0]  loadSize;
  logic        loadUnsigned;
  logic [1:0]  byteOffset;
  logic        memRdValid;
  logic [31:0] memRdData;
  logic        regWriteF;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        pendingValid;
  logic [4:0]  pendingReg;
  logic        protoErr;

  modport slave (
    input  inValid, inDest, resultSel, aluResult, linkAddr,
           loadSize, loadUnsigned, byteOffset, memRdValid, memRdData,
    output inReady, regWriteF, writeReg, writeData,
           pendingValid, pendingReg, protoErr
  );

  modport master (
    output inValid, inDest, resultSel, aluResult, linkAddr,
           loadSize, loadUnsigned, byteOffset, memRdValid, memRdData,
    input  inReady, regWriteF, writeReg, writeData,
           pendingValid, pendingReg, protoErr
  );
endinterface

// File: rtl/wb_commit.sv
// Writeback commit stage: selects ALU/link/load result and drives the single
// register-file write port; exports the outstanding load destination to decode.
//
// state    | meaning
// IDLE     | nothing to write, ready to accept
// WRITE    | write cycle for the latched result, ready to accept
// WAIT_MEM | load issued, waiting for memRdValid
module wb_commit (
  input  logic        clock,
  input  logic        resetN,
  wb_commit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_WAIT_MEM = 2'd2
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_dest;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_offset;
  logic [4:0]  r_write_reg;
  logic [31:0] r_write_data;
  logic        r_proto_err;

  logic        w_ready;
  logic        w_accept;
  logic        w_load_done;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_ext;

  assign w_ready     = (r_state != S_WAIT_MEM);
  assign w_accept    = bus.inValid & w_ready;
  assign w_load_done = (r_state == S_WAIT_MEM) & bus.memRdValid;

  // Halfword lane uses only offset[1]; a misaligned halfword simply reads its containing half.
  assign w_lane_byte = bus.memRdData[{r_offset, 3'b000} +: 8];
  assign w_lane_half = r_offset[1] ? bus.memRdData[31:16] : bus.memRdData[15:0];

  always_comb begin
    w_load_ext = bus.memRdData;
    case (r_size)
      2'b00:   w_load_ext = r_unsigned ? {24'h0, w_lane_byte}
                                       : {{24{w_lane_byte[7]}}, w_lane_byte};
      2'b01:   w_load_ext = r_unsigned ? {16'h0, w_lane_half}
                                       : {{16{w_lane_half[15]}}, w_lane_half};
      default: w_load_ext = bus.memRdData;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_WRITE: begin
        if (w_accept) begin
          case (bus.resultSel)
            SEL_ALU, SEL_LINK: w_state_nxt = S_WRITE;
            SEL_LOAD:          w_state_nxt = S_WAIT_MEM;
            default:           w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_MEM: begin
        if (bus.memRdValid) w_state_nxt = S_WRITE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_dest       <= 5'd0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_offset     <= 2'd0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_dest     <= bus.inDest;
        r_size     <= bus.loadSize;
        r_unsigned <= bus.loadUnsigned;
        r_offset   <= bus.byteOffset;
        if (bus.resultSel == SEL_ALU) begin
          r_write_reg  <= bus.inDest;
          r_write_data <= bus.aluResult;
        end else if (bus.resultSel == SEL_LINK) begin
          r_write_reg  <= bus.inDest;
          r_write_data <= bus.linkAddr;
        end
      end
      if (w_load_done) begin
        r_write_reg  <= r_dest;
        r_write_data <= w_load_ext;
      end
      if (bus.memRdValid && (r_state != S_WAIT_MEM)) r_proto_err <= 1'b1;
    end
  end

  assign bus.inReady      = w_ready;
  assign bus.regWriteF    = (r_state == S_WRITE) && (r_write_reg != 5'd0);
  assign bus.writeReg     = r_write_reg;
  assign bus.writeData    = r_write_data;
  assign bus.pendingValid = (r_state == S_WAIT_MEM) && (r_dest != 5'd0);
  assign bus.pendingReg   = (r_state == S_WAIT_MEM) ? r_dest : 5'd0;
  assign bus.protoErr     = r_proto_err;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: ALU/link/load commits, r0, no-write, reset mid-load.
module tb_wb_commit;

  logic clock;
  logic resetN;
  int   checks = 0;
  int   errors = 0;

  wb_commit_if bus ();

  wb_commit dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.inValid      = 1'b0;
    bus.inDest       = 5'd0;
    bus.resultSel    = 2'b00;
    bus.aluResult    = 32'd0;
    bus.linkAddr     = 32'd0;
    bus.loadSize     = 2'b00;
    bus.loadUnsigned = 1'b0;
    bus.byteOffset   = 2'b00;
  endtask

  task automatic issue(input logic [4:0] dest, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] link, input logic [1:0] size, input logic uns,
                       input logic [1:0] off);
    bus.inValid      = 1'b1;
    bus.inDest       = dest;
    bus.resultSel    = sel;
    bus.aluResult    = alu;
    bus.linkAddr     = link;
    bus.loadSize     = size;
    bus.loadUnsigned = uns;
    bus.byteOffset   = off;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] reg_idx, input logic [31:0] data);
    check({tag, "_we"},   {31'd0, bus.regWriteF}, 32'd1);
    check({tag, "_reg"},  {27'd0, bus.writeReg}, {27'd0, reg_idx});
    check({tag, "_data"}, bus.writeData, data);
  endtask

  // Load with a given data word, fixed wait length, then check the committed value.
  task automatic do_load(input string tag, input logic [4:0] dest, input logic [1:0] size,
                         input logic uns, input logic [1:0] off, input logic [31:0] word,
                         input logic [31:0] exp);
    issue(dest, 2'b01, 32'hAAAA_AAAA, 32'hBBBB_BBBB, size, uns, off);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check({tag, "_pend_v"}, {31'd0, bus.pendingValid}, 32'd1);
      check({tag, "_pend_r"}, {27'd0, bus.pendingReg}, {27'd0, dest});
      check({tag, "_rdy"},    {31'd0, bus.inReady}, 32'd0);
      check({tag, "_nowe"},   {31'd0, bus.regWriteF}, 32'd0);
      if (i < 2) tick();
    end
    bus.memRdValid = 1'b1;
    bus.memRdData  = word;
    tick();
    bus.memRdValid = 1'b0;
    bus.memRdData  = 32'h0;
    expect_write(tag, dest, exp);
    check({tag, "_pend_clr"}, {31'd0, bus.pendingValid}, 32'd0);
    tick();
    check({tag, "_after"}, {31'd0, bus.regWriteF}, 32'd0);
  endtask

  initial begin
    resetN         = 1'b0;
    bus.memRdValid = 1'b0;
    bus.memRdData  = 32'h0;
    idle_inputs();
    #3;
    check("rst_we",    {31'd0, bus.regWriteF}, 32'd0);
    check("rst_reg",   {27'd0, bus.writeReg}, 32'd0);
    check("rst_data",  bus.writeData, 32'd0);
    check("rst_pend",  {31'd0, bus.pendingValid}, 32'd0);
    check("rst_preg",  {27'd0, bus.pendingReg}, 32'd0);
    check("rst_perr",  {31'd0, bus.protoErr}, 32'd0);
    tick();
    resetN = 1'b1;
    tick();
    check("rel_rdy", {31'd0, bus.inReady}, 32'd1);

    // single ALU commit
    issue(5'd8, 2'b00, 32'h0000_002A, 32'h0, 2'b00, 1'b0, 2'b00);
    tick();
    idle_inputs();
    expect_write("alu", 5'd8, 32'h0000_002A);
    tick();
    check("alu_idle_we",   {31'd0, bus.regWriteF}, 32'd0);
    check("alu_hold_data", bus.writeData, 32'h0000_002A);

    // back-to-back ALU commits
    issue(5'd9, 2'b00, 32'h0000_0109, 32'h0, 2'b00, 1'b0, 2'b00);
    check("b2b_rdy0", {31'd0, bus.inReady}, 32'd1);
    tick();
    expect_write("b2b9", 5'd9, 32'h0000_0109);
    issue(5'd10, 2'b00, 32'h0000_010A, 32'h0, 2'b00, 1'b0, 2'b00);
    check("b2b_rdy1", {31'd0, bus.inReady}, 32'd1);
    tick();
    expect_write("b2b10", 5'd10, 32'h0000_010A);
    issue(5'd11, 2'b00, 32'h0000_010B, 32'h0, 2'b00, 1'b0, 2'b00);
    check("b2b_rdy2", {31'd0, bus.inReady}, 32'd1);
    tick();
    idle_inputs();
    expect_write("b2b11", 5'd11, 32'h0000_010B);
    tick();
    check("b2b_end_we", {31'd0, bus.regWriteF}, 32'd0);

    // loads: lb, lhu, lh, lbu, lw
    do_load("lb3",  5'd12, 2'b00, 1'b0, 2'd3, 32'h8000_0000, 32'hFFFF_FF80);
    do_load("lhu2", 5'd13, 2'b01, 1'b1, 2'd2, 32'h8000_0000, 32'h0000_8000);
    do_load("lh0",  5'd14, 2'b01, 1'b0, 2'd1, 32'h1234_9001, 32'hFFFF_9001);
    do_load("lbu1", 5'd15, 2'b00, 1'b1, 2'd1, 32'h11C3_2244, 32'h0000_0022);
    do_load("lw",   5'd16, 2'b11, 1'b0, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // load completion and new instruction in the same WAIT_MEM cycle
    issue(5'd17, 2'b01, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0);
    tick();
    issue(5'd18, 2'b00, 32'h0000_0055, 32'h0, 2'b00, 1'b0, 2'b00);
    bus.memRdValid = 1'b1;
    bus.memRdData  = 32'hCAFE_F00D;
    check("sim_rdy_wait", {31'd0, bus.inReady}, 32'd0);
    tick();
    bus.memRdValid = 1'b0;
    expect_write("sim_ld", 5'd17, 32'hCAFE_F00D);
    check("sim_rdy_wr", {31'd0, bus.inReady}, 32'd1);
    tick();
    idle_inputs();
    expect_write("sim_alu", 5'd18, 32'h0000_0055);
    tick();

    // write to r0 passes through WRITE without enable
    issue(5'd0, 2'b00, 32'h0000_0077, 32'h0, 2'b00, 1'b0, 2'b00);
    tick();
    idle_inputs();
    check("r0_we",   {31'd0, bus.regWriteF}, 32'd0);
    check("r0_data", bus.writeData, 32'h0000_0077);
    check("r0_rdy",  {31'd0, bus.inReady}, 32'd1);
    tick();

    // no-write instruction leaves write port untouched
    issue(5'd5, 2'b11, 32'h1111_1111, 32'h2222_2222, 2'b00, 1'b0, 2'b00);
    tick();
    idle_inputs();
    check("nw_we",   {31'd0, bus.regWriteF}, 32'd0);
    check("nw_reg",  {27'd0, bus.writeReg}, 32'd0);
    check("nw_data", bus.writeData, 32'h0000_0077);
    check("nw_pend", {31'd0, bus.pendingValid}, 32'd0);
    tick();

    // jal link write
    issue(5'd31, 2'b10, 32'h9999_9999, 32'h0040_0008, 2'b00, 1'b0, 2'b00);
    tick();
    idle_inputs();
    expect_write("jal", 5'd31, 32'h0040_0008);
    tick();
    check("pre_perr", {31'd0, bus.protoErr}, 32'd0);

    // reset in the middle of a load, then a stray return strobe
    issue(5'd20, 2'b01, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0);
    tick();
    idle_inputs();
    check("rm_pend", {31'd0, bus.pendingValid}, 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    check("rm_we",   {31'd0, bus.regWriteF}, 32'd0);
    check("rm_reg",  {27'd0, bus.writeReg}, 32'd0);
    check("rm_data", bus.writeData, 32'd0);
    check("rm_pend0", {31'd0, bus.pendingValid}, 32'd0);
    check("rm_preg",  {27'd0, bus.pendingReg}, 32'd0);
    check("rm_rdy",   {31'd0, bus.inReady}, 32'd1);
    tick();
    resetN = 1'b1;
    tick();
    bus.memRdValid = 1'b1;
    bus.memRdData  = 32'h1234_5678;
    tick();
    bus.memRdValid = 1'b0;
    check("stray_we",   {31'd0, bus.regWriteF}, 32'd0);
    check("stray_perr", {31'd0, bus.protoErr}, 32'd1);
    check("stray_data", bus.writeData, 32'd0);
    tick();
    check("perr_sticky", {31'd0, bus.protoErr}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback commit stage for the MIPS pipeline: the producer end of the register-file write port that the decode stage consumes. Accepts one retiring instruction per cycle from the memory stage, selects the result source (ALU, link address or returned load data), waits for outstanding loads, size/sign-extends load data, and drives the single register-file write (`regWriteF`, `writeReg`, `writeData`). Also exports the pending load destination so decode can stall on load-use hazards.

## Interface
Parameters: none (data width 32, register index width 5, fixed).

- `clock` in 1: sole clock, all state on rising edge
- `resetN` in 1: asynchronous, active-low reset
- `inValid` in 1: retiring instruction presented
- `inReady` out 1: stage can accept; transfer when `inValid & inReady` at a rising edge
- `inDest` in 5: destination register index, already resolved (rt/rd/31) upstream
- `resultSel` in 2: 00 ALU, 01 load, 10 link, 11 no write (store/branch)
- `aluResult` in 32: ALU result
- `linkAddr` in 32: return address for jal/jalr
- `loadSize` in 2: 00 byte, 01 half, 10 word, 11 treated as word
- `loadUnsigned` in 1: 1 zero-extend, 0 sign-extend
- `byteOffset` in 2: address bits [1:0] of the load
- `memRdValid` in 1: one-cycle strobe, load data returned
- `memRdData` in 32: returned aligned word, little-endian lanes
- `regWriteF` out 1: register-file write enable, one cycle per commit
- `writeReg` out 5: register-file write index
- `writeData` out 32: register-file write data
- `pendingValid` out 1: load outstanding to a nonzero register
- `pendingReg` out 5: destination of that load
- `protoErr` out 1: sticky, `memRdValid` seen outside WAIT_MEM

## Operation
- States: IDLE, WRITE, WAIT_MEM. Reset enters IDLE.
- `inReady` = 1 in IDLE and WRITE, 0 in WAIT_MEM (combinational from state).
- Accept in IDLE or WRITE: latch `inDest`, `loadSize`, `loadUnsigned`, `byteOffset`.
  - `resultSel` 00/10: latch `aluResult`/`linkAddr` into `writeData`, go to WRITE.
  - `resultSel` 01: go to WAIT_MEM.
  - `resultSel` 11: go to IDLE with no write.
- WRITE with no accept: go to IDLE.
- WAIT_MEM: hold until `memRdValid`. Then latch extended data into `writeData` and go to WRITE.
- Load extension:
  - Byte: `memRdData[8*byteOffset +: 8]`.
  - Half: `byteOffset[1]` selects the upper or lower halfword; `byteOffset[0]` is ignored (no misalignment trap).
  - Word: offset ignored.
  - Extend to 32 bits per `loadUnsigned`.
- `regWriteF` = 1 only in WRITE, and only when the latched dest ≠ 0. Writes to r0 still pass through WRITE for one cycle with `regWriteF` = 0.
- `writeReg`/`writeData` are registered and hold their last values outside WRITE.
- `pendingValid` = 1 in WAIT_MEM when dest ≠ 0. `pendingReg` = latched dest in WAIT_MEM, else 0.
- `protoErr`: set by `memRdValid` in IDLE or WRITE. Cleared only by reset.

## Timing
- Reset (async assert, sync-to-clock release): state IDLE, `regWriteF` 0, `writeReg` 0, `writeData` 0, `pendingValid` 0, `pendingReg` 0, `protoErr` 0; `inReady` 1 once released.
- ALU/link latency: accept at edge N, `regWriteF` high during cycle N..N+1. Back-to-back accepts give one write per cycle with no bubble.
- Load latency: accept at edge N; `memRdValid` sampled at edge M (M ≥ N+1); write in cycle M..M+1. The earliest write is the cycle after accept + 1.
- The register file writes on the edge ending the WRITE cycle. Decode reads that value the following cycle; no internal bypass.
- Reset mid-WAIT_MEM discards the load. A later stray `memRdValid` sets `protoErr`.
- `memRdValid` and `inValid` in the same WAIT_MEM cycle: the load completes and `inReady` stays 0 that cycle. The new instruction is accepted in WRITE next cycle.

## Test plan
- ALU commit: accept dest 8, ALU, `aluResult` 0x0000_002A → next cycle `regWriteF`=1, `writeReg`=8, `writeData`=0x2A; following idle cycle `regWriteF`=0.
- Back-to-back: three ALU ops to regs 9/10/11 on consecutive cycles → three consecutive write cycles, `inReady` constantly 1.
- Loads:
  - lb, dest 12, offset 3, `memRdData` 0x80_00_00_00 after 3-cycle wait → `pendingValid`=1/`pendingReg`=12 and `inReady`=0 during wait; then `writeData`=0xFFFF_FF80.
  - lhu, offset 2, same data → `writeData`=0x0000_8000.
- r0 and no-write:
  - ALU to dest 0 → WRITE cycle occurs with `regWriteF`=0.
  - `resultSel` 11 → no write, remain IDLE.
  - jal (`resultSel` 10, dest 31, `linkAddr` 0x0040_0008) → write r31 = 0x0040_0008.
- Reset mid-load: assert `resetN`=0 in WAIT_MEM → outputs zero immediately, state IDLE; after release, pulse `memRdValid` → no write, `protoErr`=1.
